// File: rtl/flag_commit_pipe_pkg.sv
// Shared definitions for the flag commit pipeline: entry layout and width.
package flag_commit_pipe_pkg;

  localparam int FLAG_ENT_W = 6;

  localparam int ENT_LD    = 0;
  localparam int ENT_Z     = 1;
  localparam int ENT_C     = 2;
  localparam int ENT_WRZ   = 3;
  localparam int ENT_WRC   = 4;
  localparam int ENT_VALID = 5;

  // Field order mirrors the ENT_* bit positions (first member is the MSB).
  typedef struct packed {
    logic valid;
    logic wr_c;
    logic wr_z;
    logic c;
    logic z;
    logic is_load;
  } flag_ent_t;

endpackage

// File: rtl/flag_commit_pipe_stage_reg.sv
// One flag pipeline entry register: async clear, synchronous bubble insert.
module flag_stage_reg
  import flag_commit_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bubble,
  input  logic [FLAG_ENT_W-1:0] d,
  output logic [FLAG_ENT_W-1:0] q
);

  logic [FLAG_ENT_W-1:0] ent_d, ent_q;

  always_comb begin
    ent_d = bubble ? '0 : d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign q = ent_q;

endmodule

// File: rtl/flag_commit_pipe.sv
// Carries C/Z flag updates EX->MEM->WB, commits them, and forwards the youngest
// in-flight values to EX. Define FLAG_FWD_EN to enable forwarding; otherwise EX stalls.
module flag_commit_pipe
  import flag_commit_pipe_pkg::*;
#(
  parameter logic RESET_C = 1'b0,
  parameter logic RESET_Z = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_valid,
  input  logic ex_wr_c,
  input  logic ex_wr_z,
  input  logic ex_carry,
  input  logic ex_zero,
  input  logic ex_is_load,
  input  logic stall,
  input  logic flush,
  input  logic mem_load_zero,
  output logic fwd_carry,
  output logic fwd_zero,
  output logic flag_hazard,
  output logic New_Carry,
  output logic New_Zero,
  output logic commit_valid
);

  flag_ent_t mem_in, wb_in, mem_ent, wb_ent;
  logic      mem_bubble, wb_bubble;

  always_comb begin
    mem_in     = {1'b1, ex_wr_c, ex_wr_z, ex_carry, ex_zero, ex_is_load};
    mem_bubble = ~(ex_valid & ~stall & ~flush);
    // Loads resolve Z in MEM; the resolved value travels on to WB.
    wb_in = mem_ent;
    if (mem_ent.valid && mem_ent.is_load) begin
      wb_in.z    = mem_load_zero;
      wb_in.wr_z = 1'b1;
    end
    wb_bubble = flush | ~mem_ent.valid;
  end

  flag_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (mem_bubble),
    .d      (mem_in),
    .q      (mem_ent)
  );

  flag_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (wb_bubble),
    .d      (wb_in),
    .q      (wb_ent)
  );

  logic arch_c_d, arch_c_q;
  logic arch_z_d, arch_z_q;
  logic commit_valid_d, commit_valid_q;

  always_comb begin
    arch_c_d       = arch_c_q;
    arch_z_d       = arch_z_q;
    commit_valid_d = 1'b0;
    if (wb_ent.valid) begin
      if (wb_ent.wr_c) arch_c_d = wb_ent.c;
      if (wb_ent.wr_z) arch_z_d = wb_ent.z;
      commit_valid_d = wb_ent.wr_c | wb_ent.wr_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_c_q       <= RESET_C;
      arch_z_q       <= RESET_Z;
      commit_valid_q <= 1'b0;
    end else begin
      arch_c_q       <= arch_c_d;
      arch_z_q       <= arch_z_d;
      commit_valid_q <= commit_valid_d;
    end
  end

  assign New_Carry    = arch_c_q;
  assign New_Zero     = arch_z_q;
  assign commit_valid = commit_valid_q;

`ifdef FLAG_FWD_EN
  logic mem_wz;

  always_comb begin
    mem_wz = mem_ent.wr_z | mem_ent.is_load;
    if (mem_ent.valid && mem_ent.wr_c)     fwd_carry = mem_ent.c;
    else if (wb_ent.valid && wb_ent.wr_c)  fwd_carry = wb_ent.c;
    else                                   fwd_carry = arch_c_q;
    if (mem_ent.valid && mem_wz)           fwd_zero = mem_ent.is_load ? mem_load_zero : mem_ent.z;
    else if (wb_ent.valid && wb_ent.wr_z)  fwd_zero = wb_ent.z;
    else                                   fwd_zero = arch_z_q;
    flag_hazard = 1'b0;
  end
`else
  always_comb begin
    fwd_carry   = arch_c_q;
    fwd_zero    = arch_z_q;
    flag_hazard = (mem_ent.valid & (mem_ent.wr_c | mem_ent.wr_z)) |
                  (wb_ent.valid  & (wb_ent.wr_c  | wb_ent.wr_z));
  end
`endif

endmodule

// File: tb/tb_flag_commit_pipe.sv
// Directed + short random bench for flag_commit_pipe with an in-flight queue model.
module tb_flag_commit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_valid = 0, ex_wr_c = 0, ex_wr_z = 0, ex_carry = 0, ex_zero = 0, ex_is_load = 0;
  logic stall = 0, flush = 0, mem_load_zero = 0;
  logic fwd_carry, fwd_zero, flag_hazard, New_Carry, New_Zero, commit_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flag_commit_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_wr_c(ex_wr_c), .ex_wr_z(ex_wr_z),
    .ex_carry(ex_carry), .ex_zero(ex_zero), .ex_is_load(ex_is_load),
    .stall(stall), .flush(flush), .mem_load_zero(mem_load_zero),
    .fwd_carry(fwd_carry), .fwd_zero(fwd_zero), .flag_hazard(flag_hazard),
    .New_Carry(New_Carry), .New_Zero(New_Zero), .commit_valid(commit_valid)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list of accepted instructions with their age (1 = in MEM, 2 = in WB).
  typedef struct {
    bit wc, wz, c, z, ld;
    int age;
  } rec_t;

  rec_t q[$];
  bit   m_c, m_z, m_cv;

  always @(posedge clk or negedge rst_n) begin
    rec_t r;
    rec_t nq[$];
    if (!rst_n) begin
      q.delete();
      m_c = 1'b0; m_z = 1'b0; m_cv = 1'b0;
    end else begin
      nq.delete();
      m_cv = 1'b0;
      foreach (q[i]) begin
        r = q[i];
        if (r.age == 2) begin
          if (r.wc) m_c = r.c;
          if (r.wz) m_z = r.z;
          m_cv = r.wc | r.wz;
        end else if (!flush) begin
          if (r.ld) begin r.z = mem_load_zero; r.wz = 1'b1; end
          r.age = 2;
          nq.push_back(r);
        end
      end
      if (ex_valid && !stall && !flush)
        nq.push_back('{ex_wr_c, ex_wr_z, ex_carry, ex_zero, ex_is_load, 1});
      q = nq;
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    bit ec, ez, eh, mld;
    if (rst_n === 1'b1) begin
      ec = m_c; ez = m_z; eh = 1'b0;
      foreach (q[i]) begin        // oldest first, so the youngest writer wins
        mld = (q[i].age == 1) && q[i].ld;
        if (q[i].wc) ec = q[i].c;
        if (q[i].wz || mld) ez = mld ? mem_load_zero : q[i].z;
        if (q[i].wc || q[i].wz) eh = 1'b1;
      end
`ifdef FLAG_FWD_EN
      eh = 1'b0;
`else
      ec = m_c; ez = m_z;
`endif
      chk("model_fwd_carry", fwd_carry, ec);
      chk("model_fwd_zero", fwd_zero, ez);
      chk("model_flag_hazard", flag_hazard, eh);
      chk("model_new_carry", New_Carry, m_c);
      chk("model_new_zero", New_Zero, m_z);
      chk("model_commit_valid", commit_valid, m_cv);
    end
  end

  task automatic drive(input bit v, wc, wz, c, z, ld, stl, fl, mlz);
    ex_valid = v; ex_wr_c = wc; ex_wr_z = wz; ex_carry = c; ex_zero = z;
    ex_is_load = ld; stall = stl; flush = fl; mem_load_zero = mlz;
  endtask

  task automatic idle(); drive(0,0,0,0,0,0,0,0,0); endtask
  task automatic tick(); @(posedge clk); #1; endtask

  initial begin
    // Reset state
    idle();
    repeat (3) tick();
    chk("rst_new_carry", New_Carry, 1'b0);
    chk("rst_new_zero", New_Zero, 1'b0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_hazard", flag_hazard, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_fwd_carry", fwd_carry, 1'b0);
    chk("rst_fwd_zero", fwd_zero, 1'b0);
    tick();

    // ADD c=1 z=0 writing both flags
    drive(1,1,1,1,0,0,0,0,0); tick(); idle(); #1;
`ifdef FLAG_FWD_EN
    chk("add_fwd_c_mem", fwd_carry, 1'b1);
`else
    chk("add_hazard_mem", flag_hazard, 1'b1);
    chk("add_fwd_c_arch", fwd_carry, 1'b0);
`endif
    tick();
`ifdef FLAG_FWD_EN
    chk("add_fwd_c_wb", fwd_carry, 1'b1);
`else
    chk("add_hazard_wb", flag_hazard, 1'b1);
`endif
    chk("add_not_yet", New_Carry, 1'b0);
    tick();
    chk("add_new_carry", New_Carry, 1'b1);
    chk("add_commit", commit_valid, 1'b1);
    chk("add_hazard_drop", flag_hazard, 1'b0);
    tick();
    chk("add_commit_pulse", commit_valid, 1'b0);

    // Back-to-back carry writers A (c=1) then B (c=0)
    drive(1,1,0,1,0,0,0,0,0); tick();
    drive(1,1,0,0,0,0,0,0,0); tick(); idle(); #1;
`ifdef FLAG_FWD_EN
    chk("b2b_mem_wins", fwd_carry, 1'b0);
`else
    chk("b2b_fwd_arch", fwd_carry, 1'b1);
`endif
    tick();
    chk("b2b_a_commit", New_Carry, 1'b1);
    tick();
    chk("b2b_final", New_Carry, 1'b0);
    tick();

    // Load: ex_zero=0, loaded data is zero
    drive(1,0,1,0,0,1,0,0,0); tick();
    drive(0,0,0,0,0,0,0,0,1); #1;
`ifdef FLAG_FWD_EN
    chk("ld_fwd_zero", fwd_zero, 1'b1);
`else
    chk("ld_fwd_zero_arch", fwd_zero, 1'b0);
`endif
    tick(); idle(); tick();
    chk("ld_new_zero", New_Zero, 1'b1);
    chk("ld_commit", commit_valid, 1'b1);
    tick();

    // Flush kills a c=1 writer in MEM
    drive(1,1,0,1,0,0,0,0,0); tick();
    drive(0,0,0,0,0,0,0,1,0); tick(); idle();
    chk("fl_cv0", commit_valid, 1'b0);
    tick();
    chk("fl_cv1", commit_valid, 1'b0);
    chk("fl_carry", New_Carry, 1'b0);
    tick();

    // Stall for two cycles behind an older writer
    drive(1,1,0,1,0,0,0,0,0); tick();
    drive(1,1,0,0,0,0,1,0,0); tick(); tick(); idle();
    chk("st_wb_commit", commit_valid, 1'b1);
    chk("st_carry", New_Carry, 1'b1);
    tick();
    chk("st_bubble", commit_valid, 1'b0);
    chk("st_carry_hold", New_Carry, 1'b1);
    tick();

    // Reset mid-flight discards the in-flight writer
    drive(1,1,1,1,1,0,0,0,0); tick(); idle();
    rst_n = 1'b0; #1;
    chk("mr_carry", New_Carry, 1'b0);
    chk("mr_zero", New_Zero, 1'b0);
    chk("mr_fwd_carry", fwd_carry, 1'b0);
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    chk("mr_no_commit", commit_valid, 1'b0);
    chk("mr_carry_after", New_Carry, 1'b0);
    chk("mr_zero_after", New_Zero, 1'b0);

    // Short random run checked by the model only
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
            $urandom_range(0,1), $urandom_range(0,1), ($urandom_range(0,3) == 0),
            ($urandom_range(0,3) == 0), ($urandom_range(0,7) == 0), $urandom_range(0,1));
      tick();
    end
    idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
